// File: rtl/mem_port_bridge.sv
// mem_port_bridge: connects the multicycle RV32I core's level-held memory
// request to a valid/ready request channel and a one-beat response channel.
// One transaction is in flight at a time. Read data and the completion pulse
// are produced from registers.
// Optional feature macro: MEM_PORT_TIMEOUT_EN. When it is defined, a WAIT
// that lasts TIMEOUT_CYCLES cycles is forced to finish with mem_err set.
module mem_port_bridge #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_address,
  input  logic [1:0]  byte_sel,
  input  logic [1:0]  mem_size,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_resp,
  output logic        mem_err,
  output logic        req_valid,
  input  logic        req_ready,
  output logic        req_we,
  output logic [31:0] req_addr,
  output logic [31:0] req_wdata,
  output logic [3:0]  req_be,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_data
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        r_req_we;
  logic [31:0] r_req_addr;
  logic [31:0] r_req_wdata;
  logic [3:0]  r_req_be;
  logic [31:0] r_mem_rdata;
  logic        r_mem_err;
  logic        w_start;
  logic        w_timeout;
  logic [3:0]  w_be;
  logic        w_unused_addr_lsb;

  // A timeout of zero cycles cannot be represented.
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("mem_port_bridge: TIMEOUT_CYCLES must be at least 1");
  end

  // Byte enables come from the access size and the offset inside the word.
  // A half access uses only byte_sel[1], so a misaligned half still lands
  // on a legal lane pair.
  function automatic logic [3:0] calc_be(input logic [1:0] size,
                                         input logic [1:0] offset);
    logic [3:0] be;
    be = 4'b1111;
    case (size)
      2'd0:    be = 4'b0001 << offset;
      2'd1:    be = 4'b0011 << {offset[1], 1'b0};
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // The low address bits are already carried by byte_sel.
  assign w_unused_addr_lsb = ^mem_address[1:0];

  assign w_start = mem_read | mem_write;
  assign w_be    = calc_be(mem_size, byte_sel);

`ifdef MEM_PORT_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CW-1:0] r_wait_cnt;
  logic [CW-1:0] w_wait_cnt_inc;

  assign w_wait_cnt_inc = r_wait_cnt + CW'(1);
  // A response that arrives in the expiry cycle takes priority.
  assign w_timeout = (r_state == ST_WAIT) && !rsp_valid &&
                     (w_wait_cnt_inc == CW'(TIMEOUT_CYCLES));

  // Count the WAIT cycles that have no response. The count is cleared
  // while in REQ, so each WAIT starts from zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wait_cnt <= '0;
    end else if (r_state == ST_REQ) begin
      r_wait_cnt <= '0;
    end else if ((r_state == ST_WAIT) && !rsp_valid) begin
      r_wait_cnt <= w_wait_cnt_inc;
    end else begin
      r_wait_cnt <= r_wait_cnt;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic. A response seen outside WAIT is stale and is ignored.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start) w_state_next = ST_REQ;
        else         w_state_next = ST_IDLE;
      end
      ST_REQ: begin
        if (req_ready) w_state_next = ST_WAIT;
        else           w_state_next = ST_REQ;
      end
      ST_WAIT: begin
        if (rsp_valid || w_timeout) w_state_next = ST_RESP;
        else                        w_state_next = ST_WAIT;
      end
      ST_RESP: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Request fields are captured when the request starts and held until the
  // next request. Read data is captured in WAIT. A timeout zeroes the read
  // data and raises the error flag for the RESP cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_req_we    <= 1'b0;
      r_req_addr  <= 32'h0000_0000;
      r_req_wdata <= 32'h0000_0000;
      r_req_be    <= 4'b0000;
      r_mem_rdata <= 32'h0000_0000;
      r_mem_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_mem_err <= 1'b0;
          if (w_start) begin
            r_req_we    <= mem_write;
            r_req_addr  <= {mem_address[31:2], 2'b00};
            r_req_wdata <= mem_wdata;
            r_req_be    <= w_be;
          end
        end
        ST_WAIT: begin
          if (rsp_valid) begin
            r_mem_err <= 1'b0;
            if (!r_req_we) r_mem_rdata <= rsp_data;
          end else if (w_timeout) begin
            r_mem_err   <= 1'b1;
            r_mem_rdata <= 32'h0000_0000;
          end
        end
        ST_RESP: begin
          r_mem_err <= 1'b0;
        end
        default: begin
          r_mem_err <= 1'b0;
        end
      endcase
    end
  end

  assign req_valid = (r_state == ST_REQ);
  assign mem_resp  = (r_state == ST_RESP);
  assign mem_err   = r_mem_err;
  assign mem_rdata = r_mem_rdata;
  assign req_we    = r_req_we;
  assign req_addr  = r_req_addr;
  assign req_wdata = r_req_wdata;
  assign req_be    = r_req_be;

endmodule

// File: tb/tb_mem_port_bridge.sv
// Directed bench for mem_port_bridge. A vector table covers the main access
// types and their stall patterns. Hand-written sequences cover stale
// responses, reset during WAIT and the WAIT timeout.
module tb_mem_port_bridge;

  logic        clk;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [1:0]  byte_sel;
  logic [1:0]  mem_size;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_resp;
  logic        mem_err;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic [31:0] rsp_data;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [1:0]  sel;
    logic [1:0]  size;
    logic [31:0] wdata;
    int          rdy_dly;
    int          rsp_dly;
    logic [31:0] rsp_data;
    logic [3:0]  exp_be;
    logic [31:0] exp_addr;
    logic        exp_we;
    logic [31:0] exp_rdata;
    int          exp_cyc;
  } vec_t;

  vec_t vecs[6];

  mem_port_bridge #(.TIMEOUT_CYCLES(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_address(mem_address),
    .byte_sel   (byte_sel),
    .mem_size   (mem_size),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_resp   (mem_resp),
    .mem_err    (mem_err),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_be     (req_be),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One transaction. The bench plays both the CPU and the memory. The CPU
  // fields are scrambled once the request is latched. Stale responses are
  // pulsed while REQ is stalled and during RESP.
  task automatic run_txn(input vec_t v);
    int req_cyc;
    int acc_cyc;
    int resp_cyc;
    bit acc;
    bit done;
    req_cyc  = 0;
    acc_cyc  = 0;
    resp_cyc = -1;
    acc      = 1'b0;
    done     = 1'b0;
    @(posedge clk); #1;
    mem_read    = v.rd;
    mem_write   = v.wr;
    mem_address = v.addr;
    byte_sel    = v.sel;
    mem_size    = v.size;
    mem_wdata   = v.wdata;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    for (int c = 1; c <= 30 && !done; c++) begin
      @(posedge clk); #1;
      mem_address = ~v.addr;
      byte_sel    = ~v.sel;
      mem_size    = ~v.size;
      mem_wdata   = ~v.wdata;
      req_ready   = 1'b0;
      rsp_valid   = 1'b0;
      rsp_data    = 32'hDEAD_BEEF;
      if (req_valid) begin
        chk("req_addr", req_addr, v.exp_addr);
        chk("req_be", 32'(req_be), 32'(v.exp_be));
        chk("req_we", 32'(req_we), 32'(v.exp_we));
        chk("req_wdata", req_wdata, v.wdata);
        if (req_cyc >= v.rdy_dly) begin
          req_ready = 1'b1;
          acc       = 1'b1;
          acc_cyc   = c;
        end else begin
          rsp_valid = 1'b1;
          rsp_data  = 32'hBAD0_BAD0;
        end
        req_cyc++;
      end else if (mem_resp) begin
        done     = 1'b1;
        resp_cyc = c;
        chk("resp_rdata", mem_rdata, v.exp_rdata);
        chk("resp_err", 32'(mem_err), 32'd0);
        rsp_valid = 1'b1;
        rsp_data  = 32'hBAD1_BAD1;
      end else if (acc && (c == acc_cyc + 1 + v.rsp_dly)) begin
        rsp_valid = 1'b1;
        rsp_data  = v.rsp_data;
      end
    end
    chk("resp_cycle", 32'(resp_cyc), 32'(v.exp_cyc));
    @(posedge clk); #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    rsp_valid = 1'b0;
    req_ready = 1'b0;
    chk("resp_pulse", 32'(mem_resp), 32'd0);
    chk("rdata_hold", mem_rdata, v.exp_rdata);
    chk("idle_valid", 32'(req_valid), 32'd0);
  endtask

  initial begin
    int   seen;
    int   tcyc;
    vec_t v;

    // Fields, in order: rd wr addr sel size wdata rdy_dly rsp_dly rsp_data
    //                   exp_be exp_addr exp_we exp_rdata exp_cyc
    vecs[0] = '{1'b1, 1'b0, 32'h0000_0100, 2'd0, 2'd2, 32'h0000_0000, 0, 0, 32'hCAFE_F00D,
                4'b1111, 32'h0000_0100, 1'b0, 32'hCAFE_F00D, 3};
    vecs[1] = '{1'b0, 1'b1, 32'h0000_0200, 2'd2, 2'd0, 32'h00AB_0000, 3, 0, 32'h1111_1111,
                4'b0100, 32'h0000_0200, 1'b1, 32'hCAFE_F00D, 6};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0306, 2'd2, 2'd1, 32'h0000_0000, 0, 0, 32'h1234_5678,
                4'b1100, 32'h0000_0304, 1'b0, 32'h1234_5678, 3};
    vecs[3] = '{1'b0, 1'b1, 32'h0000_0400, 2'd0, 2'd1, 32'h0000_BEEF, 0, 2, 32'h2222_2222,
                4'b0011, 32'h0000_0400, 1'b1, 32'h1234_5678, 5};
    vecs[4] = '{1'b1, 1'b1, 32'h0000_0500, 2'd1, 2'd3, 32'h1122_3344, 0, 0, 32'hFFFF_0000,
                4'b1111, 32'h0000_0500, 1'b1, 32'h1234_5678, 3};
    vecs[5] = '{1'b1, 1'b0, 32'h0000_0600, 2'd3, 2'd0, 32'h0000_0000, 1, 1, 32'h89AB_CDEF,
                4'b1000, 32'h0000_0600, 1'b0, 32'h89AB_CDEF, 5};

    rst         = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_address = 32'h0;
    byte_sel    = 2'd0;
    mem_size    = 2'd0;
    mem_wdata   = 32'h0;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    rsp_data    = 32'h0;

    #2;
    chk("rst_rdata", mem_rdata, 32'h0);
    chk("rst_resp", 32'(mem_resp), 32'd0);
    chk("rst_err", 32'(mem_err), 32'd0);
    chk("rst_valid", 32'(req_valid), 32'd0);
    chk("rst_we", 32'(req_we), 32'd0);
    chk("rst_addr", req_addr, 32'h0);
    chk("rst_wdata", req_wdata, 32'h0);
    chk("rst_be", 32'(req_be), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_txn(vecs[i]);
    end

    // Stale responses while IDLE must not move the FSM or the read data.
    @(posedge clk); #1;
    rsp_valid = 1'b1;
    rsp_data  = 32'h5555_AAAA;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("stale_valid", 32'(req_valid), 32'd0);
      chk("stale_resp", 32'(mem_resp), 32'd0);
      chk("stale_rdata", mem_rdata, 32'h89AB_CDEF);
    end
    rsp_valid = 1'b0;
    v = '{1'b1, 1'b0, 32'h0000_0700, 2'd0, 2'd2, 32'h0, 0, 0, 32'h0BAD_CAFE,
          4'b1111, 32'h0000_0700, 1'b0, 32'h0BAD_CAFE, 3};
    run_txn(v);

    // Reset asserted in WAIT. The response that arrives late is dropped.
    @(posedge clk); #1;
    mem_read    = 1'b1;
    mem_address = 32'h0000_0800;
    byte_sel    = 2'd0;
    mem_size    = 2'd2;
    @(posedge clk); #1;
    chk("rw_req_valid", 32'(req_valid), 32'd1);
    req_ready = 1'b1;
    @(posedge clk); #1;
    req_ready = 1'b0;
    #2;
    rst      = 1'b0;
    mem_read = 1'b0;
    #1;
    chk("rw_valid", 32'(req_valid), 32'd0);
    chk("rw_resp", 32'(mem_resp), 32'd0);
    chk("rw_rdata", mem_rdata, 32'h0);
    chk("rw_addr", req_addr, 32'h0);
    chk("rw_be", 32'(req_be), 32'd0);
    @(posedge clk); #1;
    rst       = 1'b1;
    rsp_valid = 1'b1;
    rsp_data  = 32'h7777_7777;
    @(posedge clk); #1;
    rsp_valid = 1'b0;
    chk("late_valid", 32'(req_valid), 32'd0);
    chk("late_resp", 32'(mem_resp), 32'd0);
    chk("late_rdata", mem_rdata, 32'h0);
    @(posedge clk); #1;
    chk("late_resp2", 32'(mem_resp), 32'd0);
    v = '{1'b1, 1'b0, 32'h0000_0900, 2'd1, 2'd0, 32'h0, 0, 1, 32'h0000_3C00,
          4'b0010, 32'h0000_0900, 1'b0, 32'h0000_3C00, 4};
    run_txn(v);

    // Memory accepts the request and then never responds.
    @(posedge clk); #1;
    mem_read    = 1'b1;
    mem_address = 32'h0000_0A00;
    byte_sel    = 2'd0;
    mem_size    = 2'd2;
    seen        = 0;
    tcyc        = -1;
`ifdef MEM_PORT_TIMEOUT_EN
    for (int c = 1; c <= 30 && seen == 0; c++) begin
      @(posedge clk); #1;
      req_ready = req_valid;
      rsp_valid = 1'b0;
      if (mem_resp) begin
        seen = 1;
        tcyc = c;
        chk("to_err", 32'(mem_err), 32'd1);
        chk("to_rdata", mem_rdata, 32'h0);
      end
    end
    chk("to_cycle", 32'(tcyc), 32'd10);
    @(posedge clk); #1;
    mem_read  = 1'b0;
    req_ready = 1'b0;
    chk("to_err_drop", 32'(mem_err), 32'd0);
    chk("to_resp_drop", 32'(mem_resp), 32'd0);
`else
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      req_ready = req_valid;
      rsp_valid = 1'b0;
      if (mem_resp) seen++;
    end
    chk("nto_resp_count", 32'(seen), 32'd0);
    chk("nto_err", 32'(mem_err), 32'd0);
    chk("nto_valid", 32'(req_valid), 32'd0);
    chk("nto_rdata", mem_rdata, 32'h0000_3C00);
    mem_read = 1'b0;
    rst      = 1'b0;
    #2;
    rst = 1'b1;
`endif

    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
